// File: rtl/ps2_pkg.sv
// Shared scancode constants, decoder state encoding and event layout for the
// PS/2 key event decoder.
package ps2_pkg;

  localparam logic [7:0] PREFIX_E0 = 8'hE0;
  localparam logic [7:0] PREFIX_F0 = 8'hF0;
  localparam logic [7:0] PREFIX_E1 = 8'hE1;
  localparam logic [7:0] BAT_OK    = 8'hAA;
  localparam logic [7:0] ACK       = 8'hFA;
  localparam logic [7:0] ECHO      = 8'hEE;
  localparam logic [7:0] RESEND    = 8'hFE;
  localparam logic [7:0] ERR_00    = 8'h00;
  localparam logic [7:0] ERR_FF    = 8'hFF;

  // Extended-sequence fake shifts the keyboard wraps around some keys
  localparam logic [7:0] FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] FAKE_SHIFT_R = 8'h59;

  localparam int EVT_W      = 10;
  localparam int PAUSE_SKIP = 7;

  localparam logic [7:0] GK_W     = 8'h1D;
  localparam logic [7:0] GK_A     = 8'h1C;
  localparam logic [7:0] GK_S     = 8'h1B;
  localparam logic [7:0] GK_D     = 8'h23;
  localparam logic [7:0] GK_UP    = 8'h75;
  localparam logic [7:0] GK_LEFT  = 8'h6B;
  localparam logic [7:0] GK_DOWN  = 8'h72;
  localparam logic [7:0] GK_RIGHT = 8'h74;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_SKIP_E1
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  function automatic logic is_housekeeping(input logic [7:0] b);
    return (b == BAT_OK) || (b == ACK) || (b == ECHO) || (b == RESEND) ||
           (b == ERR_00) || (b == ERR_FF);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PREFIX_E0) || (b == PREFIX_F0) || (b == PREFIX_E1);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == FAKE_SHIFT_L) || (b == FAKE_SHIFT_R);
  endfunction

  // One-hot bitmap position for the tracked game keys, zero for all others
  function automatic logic [7:0] game_key_mask(input logic [7:0] code, input logic ext);
    logic [7:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        GK_W:    m[0] = 1'b1;
        GK_A:    m[1] = 1'b1;
        GK_S:    m[2] = 1'b1;
        GK_D:    m[3] = 1'b1;
        default: m = '0;
      endcase
    end else begin
      case (code)
        GK_UP:    m[4] = 1'b1;
        GK_LEFT:  m[5] = 1'b1;
        GK_DOWN:  m[6] = 1'b1;
        GK_RIGHT: m[7] = 1'b1;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Key event stream: valid/ready handshake carrying one decoded make/break event.
interface ps2_key_event_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_extended;
  logic       evt_release;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_extended,
    output evt_release,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_extended,
    input  evt_release,
    output evt_ready
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted when
// a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Folds PS/2 Set-2 scancode sequences into make/break key events buffered in a FIFO.
// Optional held-key bitmap output enabled by defining PS2_GAME_KEYS_EN.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode_in,
  input  logic       keycode_valid_in,
  input  logic       rx_error_in,
  ps2_key_event_decoder_if.master evt,
  output logic       decode_error,
  output logic       overflow,
  input  logic       overflow_clr
`ifdef PS2_GAME_KEYS_EN
  ,
  output logic [7:0] game_keys
`endif
);

  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

  dec_state_t  state_q;
  dec_state_t  next_state;
  logic [2:0]  skip_q;
  logic [2:0]  next_skip;
  logic [TW-1:0] timer_q;
  logic        rx_err_q;
  logic        rx_rise;
  logic        abort;
  logic        push;
  key_event_t  push_evt;
  key_event_t  head_evt;
  logic        fifo_full;
  logic        fifo_empty;
  logic        drop;

  assign rx_rise = rx_error_in & ~rx_err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      skip_q       <= '0;
      rx_err_q     <= 1'b0;
      decode_error <= 1'b0;
    end else begin
      state_q      <= next_state;
      skip_q       <= next_skip;
      rx_err_q     <= rx_error_in;
      decode_error <= abort;
    end
  end

  // A receiver error edge outranks a byte arriving in the same cycle
  always_comb begin
    next_state = state_q;
    next_skip  = skip_q;
    push       = 1'b0;
    push_evt   = '0;
    abort      = 1'b0;
    if ((state_q != ST_IDLE) && rx_rise) begin
      abort = 1'b1;
    end else if (keycode_valid_in) begin
      unique case (state_q)
        ST_IDLE: begin
          if (keycode_in == PREFIX_E0) begin
            next_state = ST_GOT_E0;
          end else if (keycode_in == PREFIX_F0) begin
            next_state = ST_GOT_F0;
          end else if (keycode_in == PREFIX_E1) begin
            next_state = ST_SKIP_E1;
            next_skip  = 3'(PAUSE_SKIP);
          end else if (!is_housekeeping(keycode_in)) begin
            push     = 1'b1;
            push_evt = key_event_t'{ext: 1'b0, rel: 1'b0, code: keycode_in};
          end
        end
        ST_GOT_E0: begin
          if (keycode_in == PREFIX_F0) begin
            next_state = ST_GOT_E0F0;
          end else if (is_fake_shift(keycode_in)) begin
            next_state = ST_IDLE;
          end else if (is_prefix(keycode_in)) begin
            abort = 1'b1;
          end else begin
            push       = 1'b1;
            push_evt   = key_event_t'{ext: 1'b1, rel: 1'b0, code: keycode_in};
            next_state = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          if (is_prefix(keycode_in)) begin
            abort = 1'b1;
          end else begin
            push       = 1'b1;
            push_evt   = key_event_t'{ext: 1'b0, rel: 1'b1, code: keycode_in};
            next_state = ST_IDLE;
          end
        end
        ST_GOT_E0F0: begin
          if (is_fake_shift(keycode_in)) begin
            next_state = ST_IDLE;
          end else if (is_prefix(keycode_in)) begin
            abort = 1'b1;
          end else begin
            push       = 1'b1;
            push_evt   = key_event_t'{ext: 1'b1, rel: 1'b1, code: keycode_in};
            next_state = ST_IDLE;
          end
        end
        ST_SKIP_E1: begin
          next_skip = skip_q - 1'b1;
          if (skip_q == 3'd1) begin
            push       = 1'b1;
            push_evt   = key_event_t'{ext: 1'b0, rel: 1'b0, code: PREFIX_E1};
            next_state = ST_IDLE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (timer_q == TW'(PREFIX_TIMEOUT))) begin
      abort = 1'b1;
    end
    if (abort) next_state = ST_IDLE;
  end

  // Holds the number of cycles since the last accepted byte of an open sequence
  always_ff @(posedge clk) begin
    if (!reset_n || abort) begin
      timer_q <= '0;
    end else if (keycode_valid_in) begin
      timer_q <= TW'(1);
    end else if (state_q != ST_IDLE) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_evt),
    .pop       (evt.evt_ready),
    .head_data (head_evt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt.evt_valid    = ~fifo_empty;
  assign evt.evt_code     = head_evt.code;
  assign evt.evt_extended = head_evt.ext;
  assign evt.evt_release  = head_evt.rel;

  // A full FIFO is never empty, so ready alone means a pop frees a slot
  assign drop = push & fifo_full & ~evt.evt_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef PS2_GAME_KEYS_EN
  logic [7:0] gk_mask;
  assign gk_mask = game_key_mask(push_evt.code, push_evt.ext);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      game_keys <= '0;
    end else if (push) begin
      game_keys <= push_evt.rel ? (game_keys & ~gk_mask) : (game_keys | gk_mask);
    end
  end
`endif

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Self-checking bench: directed test-plan sequences plus randomized byte streams
// compared every cycle against a sequence-level reference model.
module tb_ps2_key_event_decoder;

  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] keycode_in = 8'h00;
  logic       keycode_valid_in = 1'b0;
  logic       rx_error_in = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       decode_error;
  logic       overflow;
`ifdef PS2_GAME_KEYS_EN
  logic [7:0] game_keys;
`endif

  ps2_key_event_decoder_if evt_bus();

  ps2_key_event_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .PREFIX_TIMEOUT (TMO)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .keycode_in       (keycode_in),
    .keycode_valid_in (keycode_valid_in),
    .rx_error_in      (rx_error_in),
    .evt              (evt_bus),
    .decode_error     (decode_error),
    .overflow         (overflow),
    .overflow_clr     (overflow_clr)
`ifdef PS2_GAME_KEYS_EN
    ,
    .game_keys        (game_keys)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: pending sequence bytes and queued events {ext,rel,code}
  logic [9:0] m_fifo[$];
  logic [7:0] m_seq[$];
  int         m_since = 0;
  logic       m_rx_prev = 1'b0;
  logic       m_derr = 1'b0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_keys = 8'h00;

  logic [7:0] gk_code [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74};
  logic       gk_ext  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_hk(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  task automatic model_byte(input logic [7:0] b, output bit abort, output bit emit,
                            output logic [9:0] ev);
    bit ext;
    bit rel;
    abort = 0;
    emit  = 0;
    ev    = '0;
    if (m_seq.size() == 0) begin
      if (b inside {8'hE0, 8'hF0, 8'hE1}) m_seq.push_back(b);
      else if (!is_hk(b)) begin emit = 1; ev = {2'b00, b}; end
    end else if (m_seq[0] == 8'hE1) begin
      m_seq.push_back(b);
      if (m_seq.size() == 8) begin
        emit = 1;
        ev = {2'b00, 8'hE1};
        m_seq.delete();
      end
    end else begin
      ext = (m_seq[0] == 8'hE0);
      rel = (m_seq[m_seq.size()-1] == 8'hF0);
      if (b == 8'hF0 && ext && !rel) begin
        m_seq.push_back(b);
      end else if (b inside {8'hE0, 8'hE1, 8'hF0}) begin
        abort = 1;
      end else begin
        m_seq.delete();
        if (!(ext && (b inside {8'h12, 8'h59}))) begin
          emit = 1;
          ev = {ext, rel, b};
        end
      end
    end
  endtask

  task automatic model_step();
    bit pop;
    bit abort;
    bit emit;
    bit drop;
    logic [9:0] ev;
    if (!reset_n) begin
      m_fifo.delete();
      m_seq.delete();
      m_since = 0;
      m_rx_prev = 1'b0;
      m_derr = 1'b0;
      m_ovf = 1'b0;
      m_keys = 8'h00;
      return;
    end
    pop   = (m_fifo.size() > 0) && evt_bus.evt_ready;
    abort = 0;
    emit  = 0;
    ev    = '0;
    if (m_seq.size() > 0 && rx_error_in && !m_rx_prev) begin
      abort = 1;
    end else if (keycode_valid_in) begin
      model_byte(keycode_in, abort, emit, ev);
      m_since = 0;
    end else if (m_seq.size() > 0) begin
      m_since++;
      if (m_since == TMO) abort = 1;
    end
    if (abort) m_seq.delete();
    if (pop) void'(m_fifo.pop_front());
    drop = 0;
    if (emit) begin
      for (int i = 0; i < 8; i++)
        if (ev[7:0] == gk_code[i] && ev[9] == gk_ext[i]) m_keys[i] = ~ev[8];
      if (m_fifo.size() < DEPTH) m_fifo.push_back(ev);
      else drop = 1;
    end
    if (drop) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
    m_derr = abort;
    m_rx_prev = rx_error_in;
  endtask

  task automatic check_output();
    check("evt_valid", evt_bus.evt_valid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      check("evt_code", evt_bus.evt_code, m_fifo[0][7:0]);
      check("evt_extended", evt_bus.evt_extended, m_fifo[0][9]);
      check("evt_release", evt_bus.evt_release, m_fifo[0][8]);
    end
    check("decode_error", decode_error, m_derr);
    check("overflow", overflow, m_ovf);
`ifdef PS2_GAME_KEYS_EN
    check("game_keys", game_keys, m_keys);
`endif
  endtask

  always @(negedge clk) check_output();

  task automatic apply_stimulus(input logic [7:0] b, input logic v, input logic err,
                                input logic rdy, input logic clr);
    keycode_in       = b;
    keycode_valid_in = v;
    rx_error_in      = err;
    evt_bus.evt_ready = rdy;
    overflow_clr     = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    apply_stimulus(b, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_head(input string name, input logic [7:0] code, input logic ext,
                            input logic rel);
    check({name, "_valid"}, evt_bus.evt_valid, 1'b1);
    check({name, "_code"}, evt_bus.evt_code, code);
    check({name, "_ext"}, evt_bus.evt_extended, ext);
    check({name, "_rel"}, evt_bus.evt_release, rel);
  endtask

  logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'hAA, 8'hFA, 8'h1C,
                            8'h1D, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h1B, 8'h77};

  initial begin
    evt_bus.evt_ready = 1'b0;
    reset_n = 1'b0;
    idle(3);
    check("rst_valid", evt_bus.evt_valid, 1'b0);
    check("rst_code", evt_bus.evt_code, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_decode_error", decode_error, 1'b0);
    reset_n = 1'b1;
    idle(2);

    // Plain make then break
    send(8'h1C);
    check_head("make_1c", 8'h1C, 1'b0, 1'b0);
    send(8'hF0);
    send(8'h1C);
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check_head("break_1c", 8'h1C, 1'b0, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drained_1c", evt_bus.evt_valid, 1'b0);

    // Extended make/break
    send(8'hE0);
    send(8'h75);
    check_head("make_e075", 8'h75, 1'b1, 1'b0);
`ifdef PS2_GAME_KEYS_EN
    check("gk_up_set", game_keys[4], 1'b1);
`endif
    drain();
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_head("break_e075", 8'h75, 1'b1, 1'b1);
`ifdef PS2_GAME_KEYS_EN
    check("gk_up_clr", game_keys[4], 1'b0);
`endif
    drain();

    // Pause sequence and housekeeping bytes
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    check("pause_early", evt_bus.evt_valid, 1'b0);
    send(8'h77);
    check_head("pause", 8'hE1, 1'b0, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pause_single", evt_bus.evt_valid, 1'b0);
    send(8'hAA);
    send(8'hFA);
    check("housekeeping", evt_bus.evt_valid, 1'b0);

    // Prefix timeout
    send(8'hE0);
    idle(TMO - 1);
    check("tmo_early", decode_error, 1'b0);
    idle(1);
    check("tmo_pulse", decode_error, 1'b1);
    idle(1);
    check("tmo_one_cycle", decode_error, 1'b0);
    check("tmo_no_event", evt_bus.evt_valid, 1'b0);
    send(8'h1C);
    check_head("after_tmo", 8'h1C, 1'b0, 1'b0);
    drain();

    // Overflow with depth 8, push+pop when full, then clear
    for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
    check("ovf_set", overflow, 1'b1);
    check_head("ovf_head", 8'h15, 1'b0, 1'b0);
    apply_stimulus(8'h2A, 1'b1, 1'b0, 1'b1, 1'b0);
    check_head("full_pushpop", 8'h16, 1'b0, 1'b0);
    check("ovf_held", overflow, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", overflow, 1'b0);
    drain();

    // Receiver error aborts a pending break
    send(8'hF0);
    apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rxerr_pulse", decode_error, 1'b1);
    send(8'h23);
    check_head("after_rxerr", 8'h23, 1'b0, 1'b0);
    drain();

    // Randomized byte streams
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] b;
      logic       v;
      logic       err;
      if (c == 2000) begin
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 99) < 2) idle(TMO + 3);
      v = ($urandom_range(0, 99) < 40);
      b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
      err = rx_error_in;
      if ($urandom_range(0, 99) < 4) err = ~err;
      apply_stimulus(b, v, err, ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 5));
    end
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
